des_sbox_unit: RTL and testbench

- Complete DES S-box substitution stage: 48-bit expanded/key-mixed half-block in, 32-bit substituted word out (S1..S8), ahead of the P permutation in the round datapath.
- Parametrised parallelism: LANES S-boxes evaluated per cycle, so area and latency trade off per build.
- Valid/ready handshake on both sides; one transaction in flight, output held until consumed.

---
 rtl/des_sbox_pkg.sv | 29 ++
 rtl/des_sbox_lut.sv | 12 +
 rtl/des_sbox_unit.sv | 102 ++++++++++
 tb/tb_des_sbox_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_sbox_pkg.sv
// Shared constants for the DES S-box substitution stage.
// The S-box contents are stored pre-decoded, so each box is indexed directly by its 6-bit slice.
package des_sbox_pkg;

    localparam int IN_W       = 48;
    localparam int OUT_W      = 32;
    localparam int BOX_IN_W   = 6;
    localparam int BOX_OUT_W  = 4;
    localparam int SBOX_COUNT = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Row {b1,b6} and column {b2..b5} are folded into the address: entry i holds
    // the standard DES value at row {i[5],i[0]}, column i[4:1]. The first hex digit is entry 0.
    localparam logic [0:SBOX_COUNT-1][0:63][BOX_OUT_W-1:0] SBOX_TABLE = {
        256'hE04FD714_2EF2BD81_3AA66CCB_59950378_4F1CE882_D46921B7_F5CB937E_3AA0560D,
        256'hF31D84E7_6FB2384E_9C7021DA_C6095BA5_0DE87AB1_A34FD412_5B86C76C_90352EF9,
        256'hAD0790E9_6334F65A_12D8C57E_BC4B2F81_D16A4D90_86F93807_B41F2EC3_5BA5E27C,
        256'h7DD8EB35_066F90A3_1427825C_B1CA4EF9_A36F9006_CAB17DD8_F91435EB_5C27824E,
        256'h2ECB421C_74A7BD61_85503FFA_D309E896_4B281CB7_A1DE728D_F69FC059_6A3405E3,
        256'hCA1FA4F2_972C6985_06D13D4E_E07B53B8_94E3F25C_2985CF3A_7B0E41A7_16D0B86D,
        256'h4DB02BE7_F40981DA_3EC3957C_52AF6816_164BBDD8_C1347AE7_A9F5608F_0E52932C,
        256'hD12F8D48_6AF3B714_AC9536EB_500EC972_72B14E17_94CAE82D_0F6CA9D0_F335568B
    };

endpackage

// File: rtl/des_sbox_lut.sv
// One combinational S-box lookup; sel chooses S1..S8 (0..7).
module des_sbox_lut
    import des_sbox_pkg::*;
(
    input  logic [2:0]           sel,
    input  logic [BOX_IN_W-1:0]  in,
    output logic [BOX_OUT_W-1:0] out
);

    assign out = SBOX_TABLE[sel][in];

endmodule

// File: rtl/des_sbox_unit.sv
// DES S-box stage: 48-bit key-mixed half-block in, 32-bit substituted word out,
// LANES boxes evaluated per cycle, one transaction in flight.
module des_sbox_unit
    import des_sbox_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int NCYC  = SBOX_COUNT / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int SHIFT = BOX_IN_W * LANES;
    localparam int RES_W = BOX_OUT_W * LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : gen_bad_lanes
        $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  shreg;
    logic [OUT_W-1:0] acc;
    logic [RES_W-1:0] lane_res;
    logic [OUT_W-1:0] acc_next;
    logic             last_step;

    // Lane 0 always takes the most significant unprocessed slice of the shift register.
    for (genvar k = 0; k < LANES; k++) begin : gen_lane
        logic [2:0] sel;
        assign sel = 3'(int'(cnt) * LANES + k);
        des_sbox_lut u_lut (
            .sel (sel),
            .in  (shreg[IN_W-1-BOX_IN_W*k -: BOX_IN_W]),
            .out (lane_res[RES_W-1-BOX_OUT_W*k -: BOX_OUT_W])
        );
    end

    if (RES_W == OUT_W) begin : gen_acc_full
        assign acc_next = lane_res;
    end else begin : gen_acc_shift
        assign acc_next = {acc[OUT_W-RES_W-1:0], lane_res};
    end

    assign last_step = (cnt == CNT_W'(NCYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            acc   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    shreg <= shreg << SHIFT;
                    acc   <= acc_next;
                    if (last_step) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // A consumed result frees the unit, and a waiting word may enter in the same cycle.
                    if (out_ready) begin
                        if (in_valid) begin
                            shreg <= in_data;
                            cnt   <= '0;
                            state <= ST_BUSY;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == ST_DONE);
    assign in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign out_data  = acc;

endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench for des_sbox_unit: four instances (LANES = 1, 2, 4, 8) checked against
// hand-computed vectors and a row/column DES S-box reference model.
module tb_des_sbox_unit;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [3:0][47:0] in_data;
    logic [3:0][31:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        des_sbox_unit #(.LANES(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    // Standard DES tables in textbook row/column form.
    int sb_rows [8][4][16] = '{
        '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
          '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
        '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
          '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
        '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
          '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
        '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
          '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
        '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
          '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
        '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
          '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
        '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
          '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
        '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
          '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
    };

    function automatic logic [31:0] ref_model(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  six;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            six = d[47-6*b -: 6];
            r[31-4*b -: 4] = 4'(sb_rows[b][{six[5], six[0]}][six[4:1]]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One full transaction on instance idx, starting from IDLE and ending back in IDLE.
    task automatic applyStimulus(input int idx, input logic [47:0] d, input logic [31:0] exp,
                                 input int exp_lat, input string tag);
        int lat;
        checkOutput({tag, " in_ready idle"}, 64'(in_ready[idx]), 64'd1);
        in_data[idx]   = d;
        in_valid[idx]  = 1'b1;
        out_ready[idx] = 1'b0;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        in_data[idx]  = ~d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[idx] && lat < 20);
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " data"}, 64'(out_data[idx]), 64'(exp));
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
        checkOutput({tag, " out_valid cleared"}, 64'(out_valid[idx]), 64'd0);
    endtask

    typedef struct {
        int          idx;
        logic [47:0] data;
        logic [31:0] expected;
        int          latency;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] expq [$];

    initial begin
        int  lat;
        int  sent;
        int  recv;
        int  cycles;
        bit  seen;
        bit  accepted;

        vecs[0]  = '{3, 48'h000000000000, 32'hEFA72C4D, 1};
        vecs[1]  = '{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 8};
        vecs[2]  = '{1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 4};
        vecs[3]  = '{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 2};
        vecs[4]  = '{3, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 1};
        vecs[5]  = '{0, 48'h000000000000, 32'hEFA72C4D, 8};
        vecs[6]  = '{2, 48'h041041041041, 32'h03DDEAD1, 2};
        vecs[7]  = '{0, 48'h820820820820, 32'h40DA4917, 8};
        vecs[8]  = '{3, 48'h79E79E79E79E, 32'h7A8F9B17, 1};
        vecs[9]  = '{1, 48'h000000000000, 32'hEFA72C4D, 4};
        vecs[10] = '{1, 48'h001000000000, 32'hE3A72C4D, 4};
        vecs[11] = '{1, 48'h002000000000, 32'hE1A72C4D, 4};
        vecs[12] = '{1, 48'h01F000000000, 32'hE5A72C4D, 4};
        vecs[13] = '{1, 48'h020000000000, 32'hE0A72C4D, 4};
        vecs[14] = '{1, 48'h03F000000000, 32'hE9A72C4D, 4};

        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;

        // Reset behaviour on every instance.
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset in_ready[%0d]", i), 64'(in_ready[i]), 64'd0);
            checkOutput($sformatf("reset out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
            checkOutput($sformatf("reset out_data[%0d]", i), 64'(out_data[i]), 64'd0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("post-reset in_ready[%0d]", i), 64'(in_ready[i]), 64'd1);
        end

        // Directed vectors.
        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].idx, vecs[v].data, vecs[v].expected, vecs[v].latency,
                          $sformatf("vec%0d lanes%0d", v, 1 << vecs[v].idx));
        end

        // Full S2 sweep on LANES=2 with every other slice held at zero.
        for (int s = 0; s < 64; s++) begin
            logic [47:0] d;
            d = {6'd0, 6'(s), 36'd0};
            applyStimulus(1, d, ref_model(d), 4, $sformatf("s2 sweep %0d", s));
        end

        // Backpressure in DONE with the next word already waiting (LANES=2).
        in_data[1]   = 48'hFFFFFFFFFFFF;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b0;
        @(posedge clk); #1;
        in_data[1] = 48'h041041041041;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[1] && lat < 20);
        checkOutput("bp first latency", 64'(lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp stall%0d in_ready", c), 64'(in_ready[1]), 64'd0);
            checkOutput($sformatf("bp stall%0d out_valid", c), 64'(out_valid[1]), 64'd1);
            checkOutput($sformatf("bp stall%0d out_data", c), 64'(out_data[1]), 64'hD9CE3DCB);
            @(posedge clk); #1;
        end
        out_ready[1] = 1'b1;
        #1;
        checkOutput("bp release in_ready", 64'(in_ready[1]), 64'd1);
        @(posedge clk); #1;
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        in_data[1]   = '0;
        checkOutput("bp back-to-back busy", 64'(out_valid[1]), 64'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[1] && lat < 20);
        checkOutput("bp second latency", 64'(lat), 64'd4);
        checkOutput("bp second data", 64'(out_data[1]), 64'h03DDEAD1);
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        checkOutput("bp drained", 64'(out_valid[1]), 64'd0);

        // Reset in the middle of a LANES=1 transaction, at cnt==3.
        in_data[0]  = 48'hFFFFFFFFFFFF;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid-busy no out_valid", 64'(out_valid[0]), 64'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst in_ready forced low", 64'(in_ready[3]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst out_data cleared", 64'(out_data[0]), 64'd0);
        checkOutput("rst out_valid cleared", 64'(out_valid[0]), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        checkOutput("rst discarded word", 64'(seen), 64'd0);
        applyStimulus(0, 48'h820820820820, 32'h40DA4917, 8, "after rst");

        // Random traffic with random backpressure, 250 words per instance.
        for (int idx = 0; idx < 4; idx++) begin
            sent   = 0;
            recv   = 0;
            cycles = 0;
            expq.delete();
            while ((sent < 250 || expq.size() != 0) && cycles < 20000) begin
                if (!in_valid[idx] && sent < 250 && $urandom_range(0, 3) != 0) begin
                    in_data[idx]  = {16'($urandom), $urandom};
                    in_valid[idx] = 1'b1;
                end
                out_ready[idx] = ($urandom_range(0, 2) != 0);
                #1;
                accepted = in_valid[idx] && in_ready[idx];
                if (accepted) begin
                    expq.push_back(ref_model(in_data[idx]));
                    sent++;
                end
                if (out_valid[idx] && out_ready[idx]) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("[TB] FAIL rand lanes%0d spurious result: got %0h, expected none",
                                 1 << idx, out_data[idx]);
                    end else begin
                        checkOutput($sformatf("rand lanes%0d result%0d", 1 << idx, recv),
                                    64'(out_data[idx]), 64'(expq.pop_front()));
                    end
                    recv++;
                end
                @(posedge clk); #1;
                if (accepted) in_valid[idx] = 1'b0;
                cycles++;
            end
            in_valid[idx]  = 1'b0;
            out_ready[idx] = 1'b0;
            checkOutput($sformatf("rand lanes%0d results", 1 << idx), 64'(recv), 64'd250);
            checkOutput($sformatf("rand lanes%0d pending", 1 << idx), 64'(expq.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
